// File: rtl/multi_sprite_object.sv
// Draws up to N_OBJECTS fixed-size rectangles with double-buffered per-object registers.
// Latency: 1 clock pixel-to-output; no backpressure, outputs follow pixel stream every cycle.
module multi_sprite_object #(
  parameter int N_OBJECTS       = 4,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int BLINK_FRAMES    = 16,
  parameter int IDX_W           = (N_OBJECTS > 1) ? $clog2(N_OBJECTS) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [10:0]      pixelX,
  input  logic [10:0]      pixelY,
  input  logic             startOfFrame,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIndex,
  input  logic [10:0]      wrTopLeftX,
  input  logic [10:0]      wrTopLeftY,
  input  logic [7:0]       wrColor,
  input  logic             wrEnable,
  input  logic             wrBlink,
  output logic [10:0]      offsetX,
  output logic [10:0]      offsetY,
  output logic             drawingRequest,
  output logic [7:0]       RGBout,
  output logic [IDX_W-1:0] hitIndex
);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  color;
    logic        en;
    logic        blink;
  } obj_t;

  localparam obj_t OBJ_RESET = '{x: 11'd0, y: 11'd0, color: 8'hFF, en: 1'b0, blink: 1'b0};
  localparam logic [11:0] W12 = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] H12 = 12'(OBJECT_HEIGHT_Y);
  localparam logic [7:0]  LAST_FRAME = 8'(BLINK_FRAMES - 1);

  obj_t pending [N_OBJECTS];
  obj_t active  [N_OBJECTS];
  obj_t wr_obj;

  logic [7:0] frame_cnt;
  logic       blink_phase;
  logic       wr_valid;

  assign wr_obj   = '{x: wrTopLeftX, y: wrTopLeftY, color: wrColor, en: wrEnable, blink: wrBlink};
  assign wr_valid = wrEn && (32'(wrIndex) < N_OBJECTS);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N_OBJECTS; i++) begin
        pending[i] <= OBJ_RESET;
        active[i]  <= OBJ_RESET;
      end
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else begin
      for (int i = 0; i < N_OBJECTS; i++) begin
        if (wr_valid && (32'(wrIndex) == i))
          pending[i] <= wr_obj;
        // Write-through so an object written on the frame pulse shows this frame.
        if (startOfFrame)
          active[i] <= (wr_valid && (32'(wrIndex) == i)) ? wr_obj : pending[i];
      end
      if (startOfFrame) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= 8'd0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  logic [N_OBJECTS-1:0] vis_hit;

  always_comb begin
    vis_hit = '0;
    for (int i = 0; i < N_OBJECTS; i++) begin
      vis_hit[i] = active[i].en && (active[i].color != 8'hFF) &&
                   (!active[i].blink || !blink_phase) &&
                   ({1'b0, pixelX} >= {1'b0, active[i].x}) &&
                   ({1'b0, pixelX} <  ({1'b0, active[i].x} + W12)) &&
                   ({1'b0, pixelY} >= {1'b0, active[i].y}) &&
                   ({1'b0, pixelY} <  ({1'b0, active[i].y} + H12));
    end
  end

  logic             any_hit;
  logic [IDX_W-1:0] win_idx;
  obj_t             win_obj;

  // Descending scan leaves the lowest visible index as the winner.
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    win_obj = OBJ_RESET;
    for (int i = N_OBJECTS - 1; i >= 0; i--) begin
      if (vis_hit[i]) begin
        any_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_obj = active[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
      hitIndex       <= '0;
    end else if (any_hit) begin
      drawingRequest <= 1'b1;
      RGBout         <= win_obj.color;
      offsetX        <= pixelX - win_obj.x;
      offsetY        <= pixelY - win_obj.y;
      hitIndex       <= win_idx;
    end else begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'hFF;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
      hitIndex       <= '0;
    end
  end

endmodule

// File: tb/tb_multi_sprite_object.sv
// Directed bench for multi_sprite_object with hand-computed expectations.
module tb_multi_sprite_object;

  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic [10:0]      pixelX = '0, pixelY = '0;
  logic             startOfFrame = 1'b0;
  logic             wrEn = 1'b0;
  logic [IDX_W-1:0] wrIndex = '0;
  logic [10:0]      wrTopLeftX = '0, wrTopLeftY = '0;
  logic [7:0]       wrColor = '0;
  logic             wrEnable = 1'b0, wrBlink = 1'b0;
  logic [10:0]      offsetX, offsetY;
  logic             drawingRequest;
  logic [7:0]       RGBout;
  logic [IDX_W-1:0] hitIndex;

  int checks = 0;
  int failures = 0;

  multi_sprite_object #(
    .N_OBJECTS(4), .OBJECT_WIDTH_X(32), .OBJECT_HEIGHT_Y(32), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .wrEn(wrEn), .wrIndex(wrIndex),
    .wrTopLeftX(wrTopLeftX), .wrTopLeftY(wrTopLeftY), .wrColor(wrColor),
    .wrEnable(wrEnable), .wrBlink(wrBlink), .offsetX(offsetX), .offsetY(offsetY),
    .drawingRequest(drawingRequest), .RGBout(RGBout), .hitIndex(hitIndex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int col,
                        input bit en, input bit bl);
    wrEn = 1'b1; wrIndex = IDX_W'(idx);
    wrTopLeftX = 11'(x); wrTopLeftY = 11'(y);
    wrColor = 8'(col); wrEnable = en; wrBlink = bl;
  endtask

  task automatic write_obj(input int idx, input int x, input int y, input int col,
                           input bit en, input bit bl);
    @(negedge clk);
    set_wr(idx, x, y, col, en, bl);
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic sof();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  // Drive a pixel and sample outputs just after the next rising edge.
  task automatic pix(input int x, input int y);
    @(negedge clk);
    pixelX = 11'(x); pixelY = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  bit blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #12;
    chk("rst_dr", drawingRequest, 0);
    chk("rst_rgb", RGBout, 8'h00);
    chk("rst_offx", offsetX, 0);
    chk("rst_offy", offsetY, 0);
    chk("rst_idx", hitIndex, 0);
    @(negedge clk);
    resetN = 1'b1;

    // Basic hit, bottom-right inside corner, exclusive right edge
    write_obj(0, 100, 50, 8'h1C, 1, 0);
    sof();
    pix(100, 50);
    chk("basic_dr", drawingRequest, 1);
    chk("basic_rgb", RGBout, 8'h1C);
    chk("basic_offx", offsetX, 0);
    chk("basic_offy", offsetY, 0);
    chk("basic_idx", hitIndex, 0);
    pix(131, 81);
    chk("corner_dr", drawingRequest, 1);
    chk("corner_offx", offsetX, 31);
    chk("corner_offy", offsetY, 31);
    pix(132, 50);
    chk("redge_dr", drawingRequest, 0);
    chk("redge_rgb", RGBout, 8'hFF);
    chk("redge_offx", offsetX, 0);

    // Double buffering
    write_obj(0, 200, 200, 8'h1C, 1, 0);
    pix(100, 50);
    chk("dbuf_old_dr", drawingRequest, 1);
    sof();
    pix(100, 50);
    chk("dbuf_old_gone", drawingRequest, 0);
    pix(200, 200);
    chk("dbuf_new_dr", drawingRequest, 1);
    chk("dbuf_new_offx", offsetX, 0);

    // Priority and transparent objects not masking
    write_obj(0, 290, 290, 8'hE0, 1, 0);
    write_obj(2, 300, 300, 8'h03, 1, 0);
    sof();
    pix(300, 300);
    chk("prio_rgb", RGBout, 8'hE0);
    chk("prio_idx", hitIndex, 0);
    chk("prio_offx", offsetX, 10);
    write_obj(0, 290, 290, 8'hFF, 1, 0);
    sof();
    pix(300, 300);
    chk("transp_rgb", RGBout, 8'h03);
    chk("transp_idx", hitIndex, 2);
    chk("transp_offy", offsetY, 0);
    pix(295, 295);
    chk("transp_miss", drawingRequest, 0);

    // Right screen edge: clipped, no wrap
    write_obj(3, 2040, 10, 8'h55, 1, 0);
    sof();
    pix(2047, 10);
    chk("edge_dr", drawingRequest, 1);
    chk("edge_offx", offsetX, 7);
    chk("edge_idx", hitIndex, 3);
    pix(5, 10);
    chk("edge_nowrap", drawingRequest, 0);

    // Asynchronous reset mid-frame
    pix(2047, 10);
    chk("prerst_dr", drawingRequest, 1);
    #2 resetN = 1'b0;
    #1;
    chk("arst_dr", drawingRequest, 0);
    chk("arst_rgb", RGBout, 8'h00);
    chk("arst_offx", offsetX, 0);
    @(negedge clk);
    resetN = 1'b1;
    pix(2047, 10);
    chk("postrst_edge", drawingRequest, 0);
    sof();
    pix(300, 300);
    chk("postrst_sof", drawingRequest, 0);
    @(negedge clk);
    set_wr(1, 400, 400, 8'h0F, 1, 0);
    startOfFrame = 1'b1;
    @(negedge clk);
    wrEn = 1'b0; startOfFrame = 1'b0;
    pix(400, 400);
    chk("wthru_dr", drawingRequest, 1);
    chk("wthru_rgb", RGBout, 8'h0F);
    chk("wthru_idx", hitIndex, 1);

    // Blink with BLINK_FRAMES=2 from a fresh frame counter
    do_reset();
    write_obj(1, 500, 500, 8'h33, 1, 1);
    write_obj(3, 600, 600, 8'h44, 1, 0);
    for (int f = 0; f < 6; f++) begin
      sof();
      pix(500, 500);
      chk($sformatf("blink_f%0d", f + 1), drawingRequest, 32'(blink_exp[f]));
      pix(600, 600);
      chk($sformatf("steady_f%0d", f + 1), drawingRequest, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_sprite_object.md
Name: multi_sprite_object

Overview:
- Parametrised successor to the single-rectangle drawer. Draws up to N_OBJECTS fixed-size rectangles.
- Each rectangle has its own position, colour, enable and blink mode, written through a simple register-write port.
- Writes are double-buffered and take effect only at frame start, so no object tears mid-frame.
- Sits between the VGA pixel counter and the object mux. Outputs a prioritised drawingRequest, colour, in-object offsets and the index of the winning object.

Parameters:
- N_OBJECTS, 4, number of rectangles (1..16).
- OBJECT_WIDTH_X, 32, rectangle width in pixels (1..1024).
- OBJECT_HEIGHT_Y, 32, rectangle height in pixels (1..1024).
- BLINK_FRAMES, 16, frames per blink half-period (2..255).
- IDX_W, $clog2(N_OBJECTS) with minimum 1, index width (derived; do not override).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current VGA pixel column
- pixelY  in  11  current VGA pixel row
- startOfFrame  in  1  one-cycle pulse at frame start
- wrEn  in  1  write strobe for pending object registers
- wrIndex  in  IDX_W  object being written
- wrTopLeftX  in  11  new top-left X
- wrTopLeftY  in  11  new top-left Y
- wrColor  in  8  new colour; 8'hFF means transparent
- wrEnable  in  1  new object enable
- wrBlink  in  1  new blink-mode flag
- offsetX  out  11  pixelX minus winning object's topLeftX
- offsetY  out  11  pixelY minus winning object's topLeftY
- drawingRequest  out  1  some visible object covers the pixel
- RGBout  out  8  winning object's colour, or 8'hFF
- hitIndex  out  IDX_W  index of the winning object

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetN.
- Reset values:
  - All pending and active registers clear: X=0, Y=0, colour=8'hFF, enable=0, blink=0.
  - Frame counter=0, blinkPhase=0.
  - Outputs: drawingRequest=0, RGBout=8'h00, offsetX=0, offsetY=0, hitIndex=0.
- Pending registers:
  - When wrEn=1, on the clock edge, the pending set [wrIndex] is loaded with all five fields.
  - wrIndex >= N_OBJECTS: the write is ignored.
- Active registers:
  - On startOfFrame=1, every active set is copied from its pending set.
  - If wrEn and startOfFrame occur in the same cycle, the active copy for wrIndex takes the newly written values (write-through). Other indices take their old pending values.
- Blink timing:
  - The frame counter increments on each startOfFrame.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles.
  - The toggle happens in the same cycle as the active-register copy.
- Object visibility: object i is visible when all of the following hold:
  - active enable=1;
  - active colour is not 8'hFF;
  - blink=0, or blinkPhase=0.
- Hit test for object i (all arithmetic zero-extended to 12 bits so that X+W never wraps):
  - pixelX >= X and pixelX < X+OBJECT_WIDTH_X;
  - pixelY >= Y and pixelY < Y+OBJECT_HEIGHT_Y.
  - Right and bottom edges are exclusive.
- Priority: among visible, hit objects, the lowest index wins. A transparent or disabled object never masks a higher-index object.
- Output latency: exactly 1 clock from pixelX/pixelY to all outputs, registered.
  - On a hit: drawingRequest=1, RGBout=colour[win], hitIndex=win, offsets = pixel minus topLeft of the winner, truncated to 11 bits.
  - On no hit: drawingRequest=0, RGBout=8'hFF, offsets=0, hitIndex=0.
- Reset mid-frame: outputs drop to reset values asynchronously. All objects are invisible until written and a following startOfFrame occurs.
- Edge positions: objects placed partly off-screen (X+W > 2047) are clipped naturally, with no wrap to column 0.

Test Plan:
- Write object 0 at (100,50), colour 8'h1C, enable=1, then pulse startOfFrame; drive pixel (100,50) -> next cycle drawingRequest=1, RGBout=8'h1C, offset (0,0). Drive pixel (131,81) -> offset (31,31). Drive pixel (132,50) -> drawingRequest=0, RGBout=8'hFF.
- Write object 0 at (200,200) without a startOfFrame -> pixel (100,50) still hits at the old position. After startOfFrame -> pixel (100,50) misses and (200,200) hits.
- Overlap: objects 0 and 2 both cover (300,300), colours 8'hE0 and 8'h03 -> RGBout=8'hE0, hitIndex=0. Set object 0 colour to 8'hFF and pulse startOfFrame -> RGBout=8'h03, hitIndex=2.
- Blink with BLINK_FRAMES=2, object 1 blink=1 -> visible for 2 frames, hidden for 2, visible again; an object with blink=0 stays visible throughout.
- Object at X=2040, pixelX=2047 -> hit, offsetX=7. pixelX=5 -> no hit (no wrap).
- Assert resetN mid-frame while drawingRequest=1 -> outputs 0 immediately. After release, no hits until a write and a startOfFrame. A simultaneous wrEn and startOfFrame makes the written object visible in that same frame.
